// File: rtl/sspis_ctl.sv
// SPI responder (mode 0, MSB first): oversamples the pads in the clk domain, decodes a
// command byte and runs 32-bit register write or read bursts on the internal register port.
module sspis_ctl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sspis_sck,
    input  logic        sspis_ssn,
    input  logic        sspis_si,
    output logic        sspis_so,
    output logic        sspis_so_oen,
    output logic [6:0]  reg_addr,
    output logic        reg_wr,
    output logic [31:0] reg_wdata,
    output logic        reg_rd,
    input  logic [31:0] reg_rdata,
    output logic        busy
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CMD   = 2'd1;
    localparam logic [1:0] ST_WDATA = 2'd2;
    localparam logic [1:0] ST_RDATA = 2'd3;

    logic [1:0]  state;
    logic [1:0]  sck_sync;
    logic [1:0]  ssn_sync;
    logic [1:0]  si_sync;
    logic        sck_d;
    logic        sck_s;
    logic        ssn_s;
    logic        si_s;
    logic        sck_rise;
    logic        sck_fall;
    logic [30:0] rx_sh;
    logic [31:0] rx_word;
    logic [31:0] tx_sh;
    logic [4:0]  bit_cnt;
    logic        rd_ack;

    assign sck_s    = sck_sync[1];
    assign ssn_s    = ssn_sync[1];
    assign si_s     = si_sync[1];
    // Edges only count while the synchronized select is asserted.
    assign sck_rise = sck_s & ~sck_d & ~ssn_s;
    assign sck_fall = ~sck_s & sck_d & ~ssn_s;
    assign rx_word  = {rx_sh, si_s};

    assign sspis_so_oen = (state == ST_IDLE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            sck_sync  <= 2'b00;
            ssn_sync  <= 2'b11;
            si_sync   <= 2'b00;
            sck_d     <= 1'b0;
            rx_sh     <= '0;
            tx_sh     <= '0;
            bit_cnt   <= '0;
            rd_ack    <= 1'b0;
            sspis_so  <= 1'b0;
            reg_addr  <= '0;
            reg_wr    <= 1'b0;
            reg_wdata <= '0;
            reg_rd    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            sck_sync <= {sck_sync[0], sspis_sck};
            ssn_sync <= {ssn_sync[0], sspis_ssn};
            si_sync  <= {si_sync[0], sspis_si};
            sck_d    <= sck_s;
            reg_wr   <= 1'b0;
            reg_rd   <= 1'b0;
            rd_ack   <= reg_rd;

            // Write strobe is issued with the old address; advance it as the strobe ends.
            if (reg_wr) begin
                reg_addr <= reg_addr + 7'd1;
            end

            if (sck_rise) begin
                rx_sh   <= rx_word[30:0];
                bit_cnt <= bit_cnt + 5'd1;
            end

            if (state != ST_IDLE && ssn_s) begin
                state    <= ST_IDLE;
                busy     <= 1'b0;
                sspis_so <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        sspis_so <= 1'b0;
                        if (!ssn_s) begin
                            bit_cnt <= '0;
                            state   <= ST_CMD;
                            busy    <= 1'b1;
                        end
                    end
                    ST_CMD: begin
                        sspis_so <= 1'b0;
                        if (sck_rise && bit_cnt == 5'd7) begin
                            reg_addr <= rx_word[6:0];
                            bit_cnt  <= '0;
                            if (rx_word[7]) begin
                                state <= ST_WDATA;
                            end else begin
                                state  <= ST_RDATA;
                                reg_rd <= 1'b1;
                            end
                        end
                    end
                    ST_WDATA: begin
                        if (sck_rise && bit_cnt == 5'd31) begin
                            reg_wdata <= rx_word;
                            reg_wr    <= 1'b1;
                        end
                    end
                    default: begin
                        // Prefetch the next word as soon as the current one is fully clocked.
                        if (sck_rise && bit_cnt == 5'd31) begin
                            reg_addr <= reg_addr + 7'd1;
                            reg_rd   <= 1'b1;
                        end
                        if (sck_fall) begin
                            sspis_so <= tx_sh[31];
                            tx_sh    <= {tx_sh[30:0], 1'b0};
                        end
                    end
                endcase
            end

            // Read data lands one cycle after the strobe; dropped once the frame has ended.
            if (rd_ack && state == ST_RDATA) begin
                tx_sh <= reg_rdata;
            end
        end
    end
endmodule
